// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage pipelined IEEE-754 binary multiplier with valid/ready handshake.
// Round-to-nearest-even, subnormal inputs, flush-to-zero outputs, canonical qNaN, overflow to inf.
// Define FP_MUL_FLAGS_EN to add the registered {NV, OF, UF, NX} flags port.
module fp_mult_pipe #(
  parameter int unsigned EXP_W   = 5,
  parameter int unsigned FRAC_W  = 10,
  localparam int unsigned FLOAT_W = 1 + EXP_W + FRAC_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FLOAT_W-1:0] float1,
  input  logic [FLOAT_W-1:0] float2,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef FP_MUL_FLAGS_EN
  output logic [3:0]         flags,
`endif
  output logic [FLOAT_W-1:0] product
);

  localparam int unsigned PW = 2 * FRAC_W + 2;          // mantissa product width
  localparam int unsigned LW = $clog2(PW + 1);          // leading-zero count width
  localparam int unsigned XW = EXP_W + 2 + LW;          // exponent width during normalise

  localparam logic [EXP_W-1:0]        EXP_ONES = '1;
  localparam logic signed [EXP_W+1:0] BIAS     = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [XW-1:0]    EXP_MAX  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0]    ONE_X    = XW'(1);
  localparam logic [FLOAT_W-1:0]      QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // ---------------- Stage 1: unpack / classify ----------------
  logic [EXP_W-1:0]  a_exp, b_exp, a_eff, b_eff;
  logic [FRAC_W-1:0] a_frac, b_frac;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, inf_zero, sign_d, spec_d;
  logic [FLOAT_W-1:0] sval_d;
  logic signed [EXP_W+1:0] exp_sum_d;

  assign a_exp    = float1[FLOAT_W-2:FRAC_W];
  assign b_exp    = float2[FLOAT_W-2:FRAC_W];
  assign a_frac   = float1[FRAC_W-1:0];
  assign b_frac   = float2[FRAC_W-1:0];
  assign a_zero   = (a_exp == '0) && (a_frac == '0);
  assign b_zero   = (b_exp == '0) && (b_frac == '0);
  assign a_inf    = (a_exp == EXP_ONES) && (a_frac == '0);
  assign b_inf    = (b_exp == EXP_ONES) && (b_frac == '0);
  assign a_nan    = (a_exp == EXP_ONES) && (a_frac != '0);
  assign b_nan    = (b_exp == EXP_ONES) && (b_frac != '0);
  assign inf_zero = (a_inf & b_zero) | (b_inf & a_zero);
  assign sign_d   = float1[FLOAT_W-1] ^ float2[FLOAT_W-1];
  // Subnormals use an effective exponent of 1 with a zero implicit bit.
  assign a_eff    = (a_exp == '0) ? EXP_W'(1) : a_exp;
  assign b_eff    = (b_exp == '0) ? EXP_W'(1) : b_exp;
  assign exp_sum_d = $signed({2'b00, a_eff}) + $signed({2'b00, b_eff}) - BIAS;

`ifdef FP_MUL_FLAGS_EN
  logic nv_d;
  assign nv_d = (a_nan & ~a_frac[FRAC_W-1]) | (b_nan & ~b_frac[FRAC_W-1]) | inf_zero;
`endif

  // Special-case result, highest priority first.
  always_comb begin
    spec_d = 1'b1;
    sval_d = {sign_d, {(FLOAT_W-1){1'b0}}};
    if (a_nan | b_nan | inf_zero) begin
      sval_d = QNAN;
    end else if (a_inf | b_inf) begin
      sval_d = {sign_d, EXP_ONES, {FRAC_W{1'b0}}};
    end else if (!(a_zero | b_zero)) begin
      spec_d = 1'b0;
    end
  end

  logic                    s1_valid_q, s1_sign_q, s1_spec_q;
  logic signed [EXP_W+1:0] s1_exp_q;
  logic [FRAC_W:0]         s1_ma_q, s1_mb_q;
  logic [FLOAT_W-1:0]      s1_sval_q;
`ifdef FP_MUL_FLAGS_EN
  logic                    s1_nv_q;
`endif

  // Stage 1 register: classified operands.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_spec_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_ma_q    <= '0;
      s1_mb_q    <= '0;
      s1_sval_q  <= '0;
`ifdef FP_MUL_FLAGS_EN
      s1_nv_q    <= 1'b0;
`endif
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_sign_q  <= sign_d;
      s1_spec_q  <= spec_d;
      s1_exp_q   <= exp_sum_d;
      s1_ma_q    <= {a_exp != '0, a_frac};
      s1_mb_q    <= {b_exp != '0, b_frac};
      s1_sval_q  <= sval_d;
`ifdef FP_MUL_FLAGS_EN
      s1_nv_q    <= nv_d;
`endif
    end
  end

  // ---------------- Stage 2: mantissa product + leading-zero count ----------------
  logic [PW-1:0] prod_d;
  logic [LW-1:0] lzc_d;

  assign prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);

  // Highest set bit wins; an all-zero product only occurs on the special path.
  always_comb begin
    lzc_d = LW'(PW);
    for (int i = 0; i < PW; i++) begin
      if (prod_d[i]) lzc_d = LW'(PW - 1 - i);
    end
  end

  logic                    s2_valid_q, s2_sign_q, s2_spec_q;
  logic signed [EXP_W+1:0] s2_exp_q;
  logic [PW-1:0]           s2_prod_q;
  logic [LW-1:0]           s2_lzc_q;
  logic [FLOAT_W-1:0]      s2_sval_q;
`ifdef FP_MUL_FLAGS_EN
  logic                    s2_nv_q;
`endif

  // Stage 2 register: raw product.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_spec_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_prod_q  <= '0;
      s2_lzc_q   <= '0;
      s2_sval_q  <= '0;
`ifdef FP_MUL_FLAGS_EN
      s2_nv_q    <= 1'b0;
`endif
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_spec_q  <= s1_spec_q;
      s2_exp_q   <= s1_exp_q;
      s2_prod_q  <= prod_d;
      s2_lzc_q   <= lzc_d;
      s2_sval_q  <= s1_sval_q;
`ifdef FP_MUL_FLAGS_EN
      s2_nv_q    <= s1_nv_q;
`endif
    end
  end

  // ---------------- Stage 3: normalise, round, pack ----------------
  // Shift the leading one to bit PW-1; it is implicit so only the bits below it are kept.
  logic [PW-2:0]          norm;
  logic                   guard, sticky, rnd;
  logic [FRAC_W:0]        frac_r;
  logic signed [XW-1:0]   exp_ext, lzc_x, carry_x, exp_r;
  logic                   ovf, unf;
  logic [FLOAT_W-1:0]     product_d;

  assign norm    = (PW-1)'(s2_prod_q << s2_lzc_q);
  assign guard   = norm[FRAC_W];
  assign sticky  = |norm[FRAC_W-1:0];
  assign rnd     = guard & (sticky | norm[FRAC_W+1]);
  assign frac_r  = {1'b0, norm[PW-2:FRAC_W+1]} + (FRAC_W+1)'(rnd);
  assign exp_ext = {{LW{s2_exp_q[EXP_W+1]}}, s2_exp_q};
  assign lzc_x   = XW'(s2_lzc_q);
  assign carry_x = XW'(frac_r[FRAC_W]);
  assign exp_r   = exp_ext + ONE_X - lzc_x + carry_x;
  assign ovf     = exp_r >= EXP_MAX;
  assign unf     = exp_r < ONE_X;

`ifdef FP_MUL_FLAGS_EN
  logic [3:0] flags_d;
`endif

  // Final result select: special, overflow, flush-to-zero, or normal.
  always_comb begin
    product_d = {s2_sign_q, exp_r[EXP_W-1:0], frac_r[FRAC_W-1:0]};
`ifdef FP_MUL_FLAGS_EN
    flags_d   = {3'b000, guard | sticky};
`endif
    if (s2_spec_q) begin
      product_d = s2_sval_q;
`ifdef FP_MUL_FLAGS_EN
      flags_d   = {s2_nv_q, 3'b000};
`endif
    end else if (ovf) begin
      product_d = {s2_sign_q, EXP_ONES, {FRAC_W{1'b0}}};
`ifdef FP_MUL_FLAGS_EN
      flags_d   = 4'b0101;
`endif
    end else if (unf) begin
      product_d = {s2_sign_q, {(FLOAT_W-1){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
      flags_d   = 4'b0011;
`endif
    end
  end

  logic               out_valid_q;
  logic [FLOAT_W-1:0] product_q;
`ifdef FP_MUL_FLAGS_EN
  logic [3:0]         flags_q;
`endif

  // Output register: held while the consumer stalls.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      product_q   <= '0;
`ifdef FP_MUL_FLAGS_EN
      flags_q     <= '0;
`endif
    end else if (advance) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        product_q <= product_d;
`ifdef FP_MUL_FLAGS_EN
        flags_q   <= flags_d;
`endif
      end
    end
  end

  assign out_valid = out_valid_q;
  assign product   = product_q;
`ifdef FP_MUL_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule
